// File: rtl/tuner_lock_phy.sv
// rtl/tuner_lock_phy.sv - dither lock loop that walks a ring tuner code toward the local power peak
module tuner_lock_phy #(
  parameter int DAC_WIDTH  = 8,
  parameter int ADC_WIDTH  = 8,
  parameter int NUM_TARGET = 4,
  localparam int CW = $clog2(NUM_TARGET) + 1,
  localparam int IW = $clog2(NUM_TARGET)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_dig_search_peaks_val,
  output logic                             o_dig_search_peaks_rdy,
  input  logic [DAC_WIDTH*NUM_TARGET-1:0]  i_dig_ring_tune_peaks,
  input  logic [ADC_WIDTH*NUM_TARGET-1:0]  i_dig_pwr_detected_peaks,
  input  logic [CW-1:0]                    i_dig_ring_tune_peaks_cnt,
  input  logic [IW-1:0]                    i_dig_lock_target_idx,
  input  logic [DAC_WIDTH-1:0]             i_dig_lock_delta,
  input  logic                             i_dig_lock_stop,
  output logic [DAC_WIDTH-1:0]             o_dig_ring_tune,
  output logic                             o_dig_ring_tune_val,
  input  logic                             i_dig_ring_tune_rdy,
  input  logic                             i_dig_pwr_val,
  input  logic [ADC_WIDTH-1:0]             i_dig_pwr,
  output logic                             o_dig_lock_active,
  output logic                             o_dig_lock_err,
  output logic [DAC_WIDTH-1:0]             o_dig_lock_center,
  output logic [ADC_WIDTH-1:0]             o_dig_lock_center_pwr,
  output logic [15:0]                      o_dig_lock_iter_cnt,
  output logic [2:0]                       o_mon_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CAPTURE  = 3'd1,
    S_APPLY    = 3'd2,
    S_MEAS_C   = 3'd3,
    S_PROBE_UP = 3'd4,
    S_PROBE_DN = 3'd5,
    S_DECIDE   = 3'd6
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [DAC_WIDTH-1:0] r_tune, w_tune_nxt;
  logic                 r_tune_val, w_tune_val_nxt;
  logic                 r_peaks_rdy;
  logic                 r_active;
  logic                 r_err, w_err_nxt;
  logic [DAC_WIDTH-1:0] r_center, w_center_nxt;
  logic [ADC_WIDTH-1:0] r_center_pwr, w_center_pwr_nxt;
  logic [15:0]          r_iter_cnt, w_iter_cnt_nxt;
  logic [ADC_WIDTH-1:0] r_pwr_up, w_pwr_up_nxt;
  logic [ADC_WIDTH-1:0] r_pwr_dn, w_pwr_dn_nxt;
  logic [DAC_WIDTH-1:0] r_cap_code, w_cap_code_nxt;
  logic [ADC_WIDTH-1:0] r_cap_pwr, w_cap_pwr_nxt;
  logic [IW-1:0]        r_cap_idx, w_cap_idx_nxt;
  logic [CW-1:0]        r_cap_cnt, w_cap_cnt_nxt;

  logic [DAC_WIDTH-1:0] w_sel_code;
  logic [ADC_WIDTH-1:0] w_sel_pwr;
  logic [DAC_WIDTH:0]   w_up_sum;
  logic [DAC_WIDTH-1:0] w_up_code;
  logic [DAC_WIDTH-1:0] w_dn_code;
  logic [DAC_WIDTH-1:0] w_center_dec;
  logic [15:0]          w_iter_inc;

  assign w_sel_code = i_dig_ring_tune_peaks[i_dig_lock_target_idx*DAC_WIDTH +: DAC_WIDTH];
  assign w_sel_pwr  = i_dig_pwr_detected_peaks[i_dig_lock_target_idx*ADC_WIDTH +: ADC_WIDTH];

  // Probe codes clamp at the ends of the tuner range instead of wrapping
  assign w_up_sum  = {1'b0, r_center} + {1'b0, i_dig_lock_delta};
  assign w_up_code = w_up_sum[DAC_WIDTH] ? {DAC_WIDTH{1'b1}} : w_up_sum[DAC_WIDTH-1:0];
  assign w_dn_code = (i_dig_lock_delta > r_center) ? '0 : r_center - i_dig_lock_delta;

  // Up wins ties against down; a tie with the center power keeps the center
  assign w_center_dec = ((r_pwr_up > r_center_pwr) && (r_pwr_up >= r_pwr_dn)) ? w_up_code :
                        (r_pwr_dn > r_center_pwr) ? w_dn_code : r_center;

  assign w_iter_inc = (r_iter_cnt == 16'hFFFF) ? r_iter_cnt : r_iter_cnt + 16'd1;

  always_comb begin
    w_state_nxt      = r_state;
    w_tune_nxt       = r_tune;
    w_tune_val_nxt   = r_tune_val;
    w_err_nxt        = r_err;
    w_center_nxt     = r_center;
    w_center_pwr_nxt = r_center_pwr;
    w_iter_cnt_nxt   = r_iter_cnt;
    w_pwr_up_nxt     = r_pwr_up;
    w_pwr_dn_nxt     = r_pwr_dn;
    w_cap_code_nxt   = r_cap_code;
    w_cap_pwr_nxt    = r_cap_pwr;
    w_cap_idx_nxt    = r_cap_idx;
    w_cap_cnt_nxt    = r_cap_cnt;

    case (r_state)
      S_IDLE: begin
        if (i_dig_search_peaks_val && r_peaks_rdy) begin
          w_cap_code_nxt = w_sel_code;
          w_cap_pwr_nxt  = w_sel_pwr;
          w_cap_idx_nxt  = i_dig_lock_target_idx;
          w_cap_cnt_nxt  = i_dig_ring_tune_peaks_cnt;
          w_state_nxt    = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if ({1'b0, r_cap_idx} >= r_cap_cnt) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_center_nxt     = r_cap_code;
          w_center_pwr_nxt = r_cap_pwr;
          w_err_nxt        = 1'b0;
          w_iter_cnt_nxt   = 16'd0;
          w_tune_nxt       = r_cap_code;
          w_tune_val_nxt   = 1'b1;
          w_state_nxt      = S_APPLY;
        end
      end
      S_APPLY: begin
        if (r_tune_val && i_dig_ring_tune_rdy) begin
          w_tune_val_nxt = 1'b0;
          w_state_nxt    = S_MEAS_C;
        end
      end
      S_MEAS_C: begin
        if (i_dig_pwr_val) begin
          w_center_pwr_nxt = i_dig_pwr;
          w_tune_nxt       = w_up_code;
          w_tune_val_nxt   = 1'b1;
          w_state_nxt      = S_PROBE_UP;
        end
      end
      // While tune_val is high the probe is still being handed off; sampling starts after
      S_PROBE_UP: begin
        if (r_tune_val) begin
          if (i_dig_ring_tune_rdy) w_tune_val_nxt = 1'b0;
        end else if (i_dig_pwr_val) begin
          w_pwr_up_nxt   = i_dig_pwr;
          w_tune_nxt     = w_dn_code;
          w_tune_val_nxt = 1'b1;
          w_state_nxt    = S_PROBE_DN;
        end
      end
      S_PROBE_DN: begin
        if (r_tune_val) begin
          if (i_dig_ring_tune_rdy) w_tune_val_nxt = 1'b0;
        end else if (i_dig_pwr_val) begin
          w_pwr_dn_nxt = i_dig_pwr;
          w_state_nxt  = S_DECIDE;
        end
      end
      S_DECIDE: begin
        w_center_nxt   = w_center_dec;
        w_iter_cnt_nxt = w_iter_inc;
        w_tune_nxt     = w_center_dec;
        w_tune_val_nxt = 1'b1;
        w_state_nxt    = S_APPLY;
      end
      default: begin
        w_tune_val_nxt = 1'b0;
        w_state_nxt    = S_IDLE;
      end
    endcase

    if (i_dig_lock_stop && (r_state != S_IDLE)) begin
      w_state_nxt      = S_IDLE;
      w_tune_nxt       = r_tune;
      w_tune_val_nxt   = 1'b0;
      w_err_nxt        = r_err;
      w_center_nxt     = r_center;
      w_center_pwr_nxt = r_center_pwr;
      w_iter_cnt_nxt   = r_iter_cnt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_tune       <= '0;
      r_tune_val   <= 1'b0;
      r_peaks_rdy  <= 1'b1;
      r_active     <= 1'b0;
      r_err        <= 1'b0;
      r_center     <= '0;
      r_center_pwr <= '0;
      r_iter_cnt   <= 16'd0;
      r_pwr_up     <= '0;
      r_pwr_dn     <= '0;
      r_cap_code   <= '0;
      r_cap_pwr    <= '0;
      r_cap_idx    <= '0;
      r_cap_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_tune       <= w_tune_nxt;
      r_tune_val   <= w_tune_val_nxt;
      r_peaks_rdy  <= (w_state_nxt == S_IDLE);
      r_active     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_CAPTURE);
      r_err        <= w_err_nxt;
      r_center     <= w_center_nxt;
      r_center_pwr <= w_center_pwr_nxt;
      r_iter_cnt   <= w_iter_cnt_nxt;
      r_pwr_up     <= w_pwr_up_nxt;
      r_pwr_dn     <= w_pwr_dn_nxt;
      r_cap_code   <= w_cap_code_nxt;
      r_cap_pwr    <= w_cap_pwr_nxt;
      r_cap_idx    <= w_cap_idx_nxt;
      r_cap_cnt    <= w_cap_cnt_nxt;
    end
  end

  assign o_dig_search_peaks_rdy = r_peaks_rdy;
  assign o_dig_ring_tune        = r_tune;
  assign o_dig_ring_tune_val    = r_tune_val;
  assign o_dig_lock_active      = r_active;
  assign o_dig_lock_err         = r_err;
  assign o_dig_lock_center      = r_center;
  assign o_dig_lock_center_pwr  = r_center_pwr;
  assign o_dig_lock_iter_cnt    = r_iter_cnt;
  assign o_mon_state            = r_state;

endmodule

// File: tb/tb_tuner_lock_phy.sv
// tb/tb_tuner_lock_phy.sv - bench for tuner_lock_phy: vector table, hand sequences, random vs power-landscape model
module tb_tuner_lock_phy;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_dig_search_peaks_val;
  logic        o_dig_search_peaks_rdy;
  logic [31:0] i_dig_ring_tune_peaks;
  logic [31:0] i_dig_pwr_detected_peaks;
  logic [2:0]  i_dig_ring_tune_peaks_cnt;
  logic [1:0]  i_dig_lock_target_idx;
  logic [7:0]  i_dig_lock_delta;
  logic        i_dig_lock_stop;
  logic [7:0]  o_dig_ring_tune;
  logic        o_dig_ring_tune_val;
  logic        i_dig_ring_tune_rdy;
  logic        i_dig_pwr_val;
  logic [7:0]  i_dig_pwr;
  logic        o_dig_lock_active;
  logic        o_dig_lock_err;
  logic [7:0]  o_dig_lock_center;
  logic [7:0]  o_dig_lock_center_pwr;
  logic [15:0] o_dig_lock_iter_cnt;
  logic [2:0]  o_mon_state;

  always #5 clk = ~clk;

  tuner_lock_phy #(.DAC_WIDTH(8), .ADC_WIDTH(8), .NUM_TARGET(4)) dut (
    .i_clk                    (clk),
    .i_rst                    (i_rst),
    .i_dig_search_peaks_val   (i_dig_search_peaks_val),
    .o_dig_search_peaks_rdy   (o_dig_search_peaks_rdy),
    .i_dig_ring_tune_peaks    (i_dig_ring_tune_peaks),
    .i_dig_pwr_detected_peaks (i_dig_pwr_detected_peaks),
    .i_dig_ring_tune_peaks_cnt(i_dig_ring_tune_peaks_cnt),
    .i_dig_lock_target_idx    (i_dig_lock_target_idx),
    .i_dig_lock_delta         (i_dig_lock_delta),
    .i_dig_lock_stop          (i_dig_lock_stop),
    .o_dig_ring_tune          (o_dig_ring_tune),
    .o_dig_ring_tune_val      (o_dig_ring_tune_val),
    .i_dig_ring_tune_rdy      (i_dig_ring_tune_rdy),
    .i_dig_pwr_val            (i_dig_pwr_val),
    .i_dig_pwr                (i_dig_pwr),
    .o_dig_lock_active        (o_dig_lock_active),
    .o_dig_lock_err           (o_dig_lock_err),
    .o_dig_lock_center        (o_dig_lock_center),
    .o_dig_lock_center_pwr    (o_dig_lock_center_pwr),
    .o_dig_lock_iter_cnt      (o_dig_lock_iter_cnt),
    .o_mon_state              (o_mon_state)
  );

  typedef struct {
    logic [31:0]     tbl;
    int              cnt;
    int              idx;
    int              delta;
    int              peak;
    int              slope;
    bit              err;
    logic [6:0][7:0] seq;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int g_peak;
  int g_slope;
  int exp_codes[$];
  int exp_center[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Received power vs tuner code: a peak (slope>0), valley (slope<0) or flat line
  function automatic int land(input int code);
    int d;
    int p;
    d = (code > g_peak) ? code - g_peak : g_peak - code;
    p = 200 - g_slope * d;
    if (p < 0) p = 0;
    if (p > 255) p = 255;
    return p;
  endfunction

  function automatic void build_model(input int c0, input int delta, input int nloops);
    int c;
    int up;
    int dn;
    exp_codes.delete();
    exp_center.delete();
    c = c0;
    exp_codes.push_back(c);
    for (int k = 0; k < nloops; k++) begin
      up = (c + delta > 255) ? 255 : c + delta;
      dn = (c - delta < 0) ? 0 : c - delta;
      exp_codes.push_back(up);
      exp_codes.push_back(dn);
      if (land(up) > land(c) && land(up) >= land(dn)) c = up;
      else if (land(dn) > land(c)) c = dn;
      exp_codes.push_back(c);
      exp_center.push_back(c);
    end
  endfunction

  function automatic logic [31:0] tb4(input int e0, input int e1, input int e2, input int e3);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  function automatic logic [55:0] sq(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6);
    return {8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic vec_t mk(input logic [31:0] tbl, input int cnt, input int idx, input int delta,
                              input int peak, input int slope, input bit err, input logic [55:0] seq);
    vec_t v;
    v.tbl = tbl; v.cnt = cnt; v.idx = idx; v.delta = delta;
    v.peak = peak; v.slope = slope; v.err = err; v.seq = seq;
    return v;
  endfunction

  task automatic offer(input logic [31:0] tbl, input int cnt, input int idx, input int delta);
    int n;
    i_dig_ring_tune_peaks     = tbl;
    i_dig_pwr_detected_peaks  = $urandom;
    i_dig_ring_tune_peaks_cnt = 3'(cnt);
    i_dig_lock_target_idx     = 2'(idx);
    i_dig_lock_delta          = 8'(delta);
    i_dig_search_peaks_val    = 1'b1;
    n = 0;
    while (!o_dig_search_peaks_rdy && n < 50) begin
      step();
      n++;
    end
    chk("offer_rdy", int'(o_dig_search_peaks_rdy), 1);
    step();
    i_dig_search_peaks_val = 1'b0;
  endtask

  task automatic stop_lock(input int exp_ctr);
    i_dig_lock_stop = 1'b1;
    step();
    i_dig_lock_stop = 1'b0;
    chk("stop_state", int'(o_mon_state), 0);
    chk("stop_tune_val", int'(o_dig_ring_tune_val), 0);
    chk("stop_peaks_rdy", int'(o_dig_search_peaks_rdy), 1);
    chk("stop_active", int'(o_dig_lock_active), 0);
    chk("stop_center", int'(o_dig_lock_center), exp_ctr);
  endtask

  task automatic wait_state(input string name, input int s, input int budget);
    int n;
    n = 0;
    while (int'(o_mon_state) != s && n < budget) begin
      step();
      n++;
    end
    chk(name, int'(o_mon_state), s);
  endtask

  // Responds to tune handshakes with the landscape power of the last accepted code
  task automatic service(input int nhs, input int rdy_pct, input int pv_pct, input int budget);
    int   h;
    int   cyc;
    int   last_code;
    int   code;
    logic hs;
    h = 0; cyc = 0; last_code = 0;
    while (h < nhs && cyc < budget) begin
      i_dig_ring_tune_rdy = ($urandom_range(99) < rdy_pct);
      i_dig_pwr_val       = ($urandom_range(99) < pv_pct);
      i_dig_pwr           = 8'(land(last_code));
      hs   = o_dig_ring_tune_val && i_dig_ring_tune_rdy;
      code = int'(o_dig_ring_tune);
      if (o_dig_lock_active) chk("peaks_rdy_busy", int'(o_dig_search_peaks_rdy), 0);
      step();
      cyc++;
      if (hs) begin
        chk($sformatf("tune_code[%0d]", h), code, exp_codes[h]);
        if (h == 0) chk("err_cleared", int'(o_dig_lock_err), 0);
        if (h % 3 == 1) chk($sformatf("center_pwr[%0d]", h), int'(o_dig_lock_center_pwr), land(exp_codes[h-1]));
        if (h % 3 == 0 && h > 0) begin
          chk($sformatf("center[%0d]", h), int'(o_dig_lock_center), exp_center[h/3 - 1]);
          chk($sformatf("iter_cnt[%0d]", h), int'(o_dig_lock_iter_cnt), h/3);
        end
        last_code = code;
        h++;
      end
    end
    chk("service_handshakes", h, nhs);
    i_dig_ring_tune_rdy = 1'b0;
    i_dig_pwr_val       = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    int c0;
    int cnt;
    int idx;
    int delta;
    logic [31:0] tbl;

    i_rst = 1'b1;
    i_dig_search_peaks_val = 1'b0;
    i_dig_ring_tune_peaks = '0;
    i_dig_pwr_detected_peaks = '0;
    i_dig_ring_tune_peaks_cnt = '0;
    i_dig_lock_target_idx = '0;
    i_dig_lock_delta = '0;
    i_dig_lock_stop = 1'b0;
    i_dig_ring_tune_rdy = 1'b0;
    i_dig_pwr_val = 1'b0;
    i_dig_pwr = '0;

    vecs[0] = mk(tb4(40, 90, 150, 210), 4, 1, 4, 94, 3, 0, sq(90, 94, 86, 94, 98, 90, 94));
    vecs[1] = mk(tb4(1, 2, 3, 4), 2, 3, 4, 0, 3, 1, '0);
    vecs[2] = mk(tb4(10, 20, 253, 30), 4, 2, 4, 255, 3, 0, sq(253, 255, 249, 255, 255, 251, 255));
    vecs[3] = mk(tb4(2, 48, 64, 80), 1, 0, 4, 0, 3, 0, sq(2, 6, 0, 0, 4, 0, 0));
    vecs[4] = mk(tb4(1, 2, 3, 4), 0, 0, 4, 0, 3, 1, '0);
    vecs[5] = mk(tb4(1, 2, 3, 100), 4, 3, 5, 0, 0, 0, sq(100, 105, 95, 100, 105, 95, 100));
    vecs[6] = mk(tb4(5, 77, 9, 9), 2, 1, 0, 0, 1, 0, sq(77, 77, 77, 77, 77, 77, 77));
    vecs[7] = mk(tb4(60, 1, 1, 1), 1, 0, 3, 60, -2, 0, sq(60, 63, 57, 63, 66, 60, 66));
    vecs[8] = mk(tb4(9, 9, 54, 9), 3, 2, 4, 50, 2, 0, sq(54, 58, 50, 50, 54, 46, 50));

    step(); step(); step();
    chk("rst_state", int'(o_mon_state), 0);
    chk("rst_tune", int'(o_dig_ring_tune), 0);
    chk("rst_tune_val", int'(o_dig_ring_tune_val), 0);
    chk("rst_err", int'(o_dig_lock_err), 0);
    chk("rst_center", int'(o_dig_lock_center), 0);
    chk("rst_center_pwr", int'(o_dig_lock_center_pwr), 0);
    chk("rst_iter", int'(o_dig_lock_iter_cnt), 0);
    chk("rst_active", int'(o_dig_lock_active), 0);
    i_rst = 1'b0;
    step();
    chk("rst_peaks_rdy", int'(o_dig_search_peaks_rdy), 1);

    foreach (vecs[r]) begin
      g_peak  = vecs[r].peak;
      g_slope = vecs[r].slope;
      offer(vecs[r].tbl, vecs[r].cnt, vecs[r].idx, vecs[r].delta);
      if (vecs[r].err) begin
        step();
        chk($sformatf("v%0d_err", r), int'(o_dig_lock_err), 1);
        chk($sformatf("v%0d_err_state", r), int'(o_mon_state), 0);
        chk($sformatf("v%0d_err_val", r), int'(o_dig_ring_tune_val), 0);
        step();
        chk($sformatf("v%0d_err_val2", r), int'(o_dig_ring_tune_val), 0);
      end else begin
        exp_codes.delete();
        exp_center.delete();
        for (int j = 0; j < 7; j++) exp_codes.push_back(int'(vecs[r].seq[j]));
        exp_center.push_back(int'(vecs[r].seq[3]));
        exp_center.push_back(int'(vecs[r].seq[6]));
        service(7, 100, 100, 200);
        stop_lock(int'(vecs[r].seq[6]));
      end
    end

    // Stalled arbiter: power pulses before and during the handshake must be ignored
    g_peak = 94; g_slope = 3;
    offer(tb4(40, 90, 150, 210), 4, 1, 4);
    step();
    chk("stall_apply_val", int'(o_dig_ring_tune_val), 1);
    for (int k = 0; k < 10; k++) begin
      i_dig_ring_tune_rdy = 1'b0;
      i_dig_pwr_val = 1'b1;
      i_dig_pwr = 8'd11;
      i_dig_search_peaks_val = 1'b1;
      step();
      chk("stall_val", int'(o_dig_ring_tune_val), 1);
      chk("stall_code", int'(o_dig_ring_tune), 90);
      chk("stall_state", int'(o_mon_state), 2);
      chk("stall_peaks_rdy", int'(o_dig_search_peaks_rdy), 0);
    end
    i_dig_search_peaks_val = 1'b0;
    i_dig_ring_tune_rdy = 1'b1;
    step();
    chk("hs_state", int'(o_mon_state), 3);
    chk("hs_val_drop", int'(o_dig_ring_tune_val), 0);
    i_dig_ring_tune_rdy = 1'b0;
    i_dig_pwr_val = 1'b0;
    step(); step();
    chk("meas_wait", int'(o_mon_state), 3);
    i_dig_pwr_val = 1'b1;
    i_dig_pwr = 8'd123;
    step();
    i_dig_pwr_val = 1'b0;
    chk("meas_center_pwr", int'(o_dig_lock_center_pwr), 123);
    chk("meas_to_up", int'(o_mon_state), 4);
    chk("up_code", int'(o_dig_ring_tune), 94);
    i_dig_ring_tune_rdy = 1'b1;
    step();
    i_dig_ring_tune_rdy = 1'b0;
    i_dig_pwr_val = 1'b1;
    i_dig_pwr = 8'd50;
    step();
    i_dig_pwr_val = 1'b0;
    chk("dn_state", int'(o_mon_state), 5);
    chk("dn_code", int'(o_dig_ring_tune), 86);
    stop_lock(90);
    chk("stop_center_pwr", int'(o_dig_lock_center_pwr), 123);

    // Reset while a tune request is pending
    offer(tb4(40, 90, 150, 210), 4, 1, 4);
    step();
    chk("pre_rst_val", int'(o_dig_ring_tune_val), 1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("mid_rst_state", int'(o_mon_state), 0);
    chk("mid_rst_val", int'(o_dig_ring_tune_val), 0);
    chk("mid_rst_center", int'(o_dig_lock_center), 0);
    chk("mid_rst_peaks_rdy", int'(o_dig_search_peaks_rdy), 1);
    for (int k = 0; k < 4; k++) begin
      i_dig_ring_tune_rdy = 1'b1;
      i_dig_pwr_val = k[0];
      step();
      chk("post_rst_no_val", int'(o_dig_ring_tune_val), 0);
    end
    i_dig_ring_tune_rdy = 1'b0;
    i_dig_pwr_val = 1'b0;

    // Iteration counter saturation
    g_peak = 0; g_slope = 0;
    offer(tb4(1, 2, 3, 100), 4, 3, 5);
    i_dig_ring_tune_rdy = 1'b1;
    i_dig_pwr_val = 1'b1;
    i_dig_pwr = 8'd200;
    wait_state("sat_meas", 3, 20);
    force dut.r_iter_cnt = 16'hFFFE;
    step();
    release dut.r_iter_cnt;
    for (int k = 0; k < 3; k++) begin
      wait_state("sat_decide", 6, 30);
      step();
      chk($sformatf("iter_sat[%0d]", k), int'(o_dig_lock_iter_cnt), 16'hFFFF);
    end
    i_dig_ring_tune_rdy = 1'b0;
    i_dig_pwr_val = 1'b0;
    stop_lock(100);

    // Random tables, landscapes and handshake/sample timing
    for (int r = 0; r < 20; r++) begin
      tbl     = $urandom;
      cnt     = int'($urandom_range(1, 4));
      idx     = int'($urandom_range(0, cnt - 1));
      delta   = int'($urandom_range(0, 24));
      g_peak  = int'($urandom_range(0, 255));
      g_slope = int'($urandom_range(0, 6)) - 3;
      c0      = int'(tbl[idx*8 +: 8]);
      build_model(c0, delta, 4);
      offer(tbl, cnt, idx, delta);
      service(13, 60, 40, 3000);
      stop_lock(exp_center[3]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
